// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorting pipeline.
//   stage_ctl_t : per-stage control word (valid, dir)
//   stages()    : number of compare-exchange stages for N lanes
//   stage_k/j() : (k, j) pair of a given stage in standard bitonic order
//   partner()   : lane paired with lane i in a stage of distance j
//   lane_up()   : whether lane i places the smaller value in itself
package bitonic_pkg;

  typedef struct packed {
    logic valid;
    logic dir;
  } stage_ctl_t;

  function automatic int stages(input int n);
    int lg;
    lg = $clog2(n);
    return (lg * (lg + 32'sd1)) / 32'sd2;
  endfunction

  function automatic int stage_k(input int s, input int n);
    int idx;
    int res;
    idx = 32'sd0;
    res = 32'sd0;
    for (int k = 32'sd2; k <= n; k = k * 32'sd2) begin
      for (int j = k / 32'sd2; j >= 32'sd1; j = j / 32'sd2) begin
        if (idx == s) res = k;
        idx = idx + 32'sd1;
      end
    end
    return res;
  endfunction

  function automatic int stage_j(input int s, input int n);
    int idx;
    int res;
    idx = 32'sd0;
    res = 32'sd0;
    for (int k = 32'sd2; k <= n; k = k * 32'sd2) begin
      for (int j = k / 32'sd2; j >= 32'sd1; j = j / 32'sd2) begin
        if (idx == s) res = j;
        idx = idx + 32'sd1;
      end
    end
    return res;
  endfunction

  function automatic int partner(input int i, input int j);
    return i ^ j;
  endfunction

  // The bitonic block direction is flipped as a whole for descending vectors.
  function automatic logic lane_up(input int i, input int k, input logic dir);
    logic base_up;
    base_up = ((i & k) == 32'sd0);
    return base_up ? dir : ~dir;
  endfunction

endpackage

// File: rtl/bitonic_sort_pipe_if.sv
// Streaming handshake bundle of the bitonic sorter.
//   in_valid/in_ready/in_data/in_dir : input vector channel
//   out_valid/out_ready/out_data     : sorted vector channel
//   occupancy                        : vectors currently in flight
// master = producer/consumer side, slave = the sorter.
interface bitonic_sort_pipe_if #(
  parameter int DATA_W = 32,
  parameter int N      = 8
);
  localparam int OCC_W = $clog2(bitonic_pkg::stages(N) + 1);

  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic                in_dir;
  logic                out_valid;
  logic                out_ready;
  logic [N*DATA_W-1:0] out_data;
  logic [OCC_W-1:0]    occupancy;

  modport master (
    output in_valid, in_data, in_dir, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_dir, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/bitonic_cmp_swap.sv
// Single compare-exchange cell of the sorting network (combinational).
//   i_a, i_b : lane i and partner lane values
//   i_up     : 1 = smaller value to o_lo (lane i), 0 = larger value to o_lo
//   o_lo     : result for lane i
//   o_hi     : result for the partner lane
// Equal values pass straight through, keeping element-level stability.
module bitonic_cmp_swap #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_up,
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_hi
);

  logic [DATA_W-1:0] w_key_a;
  logic [DATA_W-1:0] w_key_b;
  logic              w_swap;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_key_a = {i_a[DATA_W-1] ^ SIGNED, i_a[DATA_W-2:0]};
  assign w_key_b = {i_b[DATA_W-1] ^ SIGNED, i_b[DATA_W-2:0]};
  assign w_swap  = i_up ? (w_key_a > w_key_b) : (w_key_b > w_key_a);

  // Route the pair straight or crossed.
  always_comb begin
    o_lo = i_a;
    o_hi = i_b;
    if (w_swap) begin
      o_lo = i_b;
      o_hi = i_a;
    end else begin
      o_lo = i_a;
      o_hi = i_b;
    end
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter: one N-lane vector per clock, per-vector
// sort direction, one compare-exchange level per registered stage.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of bitonic_sort_pipe_if (handshakes, data, occupancy)
// The whole pipeline stalls while the output holds a vector the consumer
// does not take; otherwise every stage advances, bubbles included.
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  bitonic_sort_pipe_if.slave bus
);

  localparam int STAGES = stages(N);
  localparam int OCC_W  = $clog2(STAGES + 1);
  localparam int VEC_W  = N * DATA_W;

  stage_ctl_t                     r_ctl  [STAGES];
  logic [VEC_W-1:0]               r_data [STAGES];
  logic [OCC_W-1:0]               r_occ;
  logic [STAGES-1:0][VEC_W-1:0]   w_din;
  logic [STAGES-1:0][VEC_W-1:0]   w_dout;
  logic [STAGES-1:0]              w_dir_in;
  logic                           w_stall;
  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_pop;

  assign w_stall    = r_ctl[STAGES-1].valid & ~bus.out_ready;
  assign w_in_ready = rst & ~w_stall;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_pop      = r_ctl[STAGES-1].valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_ctl[STAGES-1].valid;
  assign bus.out_data  = r_data[STAGES-1];
  assign bus.occupancy = r_occ;

  // Compare-exchange network: stage s works on the previous stage register
  // (or the input for stage 0) and feeds its own register.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int K = stage_k(s, N);
    localparam int J = stage_j(s, N);

    if (s == 0) begin : g_first
      assign w_din[s]    = bus.in_data;
      assign w_dir_in[s] = bus.in_dir;
    end else begin : g_next
      assign w_din[s]    = r_data[s-1];
      assign w_dir_in[s] = r_ctl[s-1].dir;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
      if (partner(i, J) > i) begin : g_cx
        localparam int P = partner(i, J);
        logic w_up;
        assign w_up = lane_up(i, K, w_dir_in[s]);

        bitonic_cmp_swap #(
          .DATA_W (DATA_W),
          .SIGNED (SIGNED)
        ) u_cx (
          .i_a  (w_din[s][i*DATA_W +: DATA_W]),
          .i_b  (w_din[s][P*DATA_W +: DATA_W]),
          .i_up (w_up),
          .o_lo (w_dout[s][i*DATA_W +: DATA_W]),
          .o_hi (w_dout[s][P*DATA_W +: DATA_W])
        );
      end
    end
  end

  // Stage registers: advance together unless the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_ctl[s]  <= '0;
        r_data[s] <= '0;
      end
    end else if (!w_stall) begin
      r_ctl[0]  <= stage_ctl_t'{valid: w_accept, dir: bus.in_dir};
      r_data[0] <= w_dout[0];
      for (int s = 1; s < STAGES; s++) begin
        r_ctl[s]  <= r_ctl[s-1];
        r_data[s] <= w_dout[s];
      end
    end
  end

  // In-flight counter: simultaneous accept and delivery cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench: an unsigned and a signed sorter receive identical
// stimulus; accepted vectors are sorted by a reference insertion sort into
// per-instance queues that are popped as sorted vectors are delivered.
module tb_bitonic_sort_pipe;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int ST = 6;
  localparam int VW = N * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitonic_sort_pipe_if #(.DATA_W(W), .N(N)) bus_u ();
  bitonic_sort_pipe_if #(.DATA_W(W), .N(N)) bus_s ();

  assign bus_s.in_valid  = bus_u.in_valid;
  assign bus_s.in_data   = bus_u.in_data;
  assign bus_s.in_dir    = bus_u.in_dir;
  assign bus_s.out_ready = bus_u.out_ready;

  bitonic_sort_pipe #(.DATA_W(W), .N(N), .SIGNED(1'b0)) dut_u (
    .clk (clk), .rst (rst), .bus (bus_u)
  );
  bitonic_sort_pipe #(.DATA_W(W), .N(N), .SIGNED(1'b1)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] qu[$];
  logic [VW-1:0] qs[$];
  logic          pu, ps, under;
  logic [VW-1:0] obs_u, obs_s, exp_u, exp_s;

  function automatic logic [W-1:0] key(input logic [W-1:0] x, input logic sgn);
    return {x[W-1] ^ sgn, x[W-2:0]};
  endfunction

  function automatic logic [VW-1:0] sort_ref(input logic [VW-1:0] v, input logic dir,
                                             input logic sgn);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (dir ? (key(a[j], sgn) < key(a[j-1], sgn)) : (key(a[j], sgn) > key(a[j-1], sgn))) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  function automatic logic [VW-1:0] pack(input logic [W-1:0] a [N]);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = (i % 2 == 0) ? $urandom_range(0, 7) : $urandom;
    return r;
  endfunction

  // One clock of stimulus; records acceptance and delivery into the scoreboard.
  task automatic drive_cycle(input logic v, input logic [VW-1:0] d, input logic dir,
                             input logic ordy);
    @(negedge clk);
    bus_u.in_valid  = v;
    bus_u.in_data   = d;
    bus_u.in_dir    = dir;
    bus_u.out_ready = ordy;
    #1;
    pu = bus_u.out_valid && bus_u.out_ready;
    ps = bus_s.out_valid && bus_s.out_ready;
    obs_u = bus_u.out_data;
    obs_s = bus_s.out_data;
    under = 1'b0;
    exp_u = '0;
    exp_s = '0;
    if (pu) begin
      if (qu.size() > 0) exp_u = qu.pop_front(); else under = 1'b1;
    end
    if (ps) begin
      if (qs.size() > 0) exp_s = qs.pop_front(); else under = 1'b1;
    end
    if (bus_u.in_valid && bus_u.in_ready) begin
      qu.push_back(sort_ref(d, dir, 1'b0));
      qs.push_back(sort_ref(d, dir, 1'b1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_u.in_valid = 1'b1; bus_u.in_data = rand_vec(); bus_u.in_dir = 1'b1;
    bus_u.out_ready = 1'b1;
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus_u.in_ready !== 1'b0 || bus_u.out_valid !== 1'b0 || bus_u.occupancy !== 3'd0 ||
          bus_u.out_data !== '0 || bus_s.out_valid !== 1'b0 || bus_s.out_data !== '0) begin
        errors++;
        $display("FAIL reset: in_ready=%b out_valid=%b occ=%0d data=%h, want 0,0,0,0",
                 bus_u.in_ready, bus_u.out_valid, bus_u.occupancy, bus_u.out_data);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus_u.in_valid = 1'b0;
  endtask

  task automatic test_single(input logic dir);
    logic [W-1:0] lanes [N];
    logic [VW-1:0] want;
    int first, pops;
    lanes = '{32'd7, 32'd3, 32'd5, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    for (int i = 0; i < N; i++) want[i*W +: W] = dir ? W'(i + 1) : W'(N - i);
    first = -1; pops = 0;
    drive_cycle(1'b1, pack(lanes), dir, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      if (pu) begin
        pops++;
        if (first < 0) first = c;
        checks++;
        if (obs_u !== want || under || obs_u !== exp_u || obs_s !== exp_s) begin
          errors++;
          $display("FAIL single_dir%0b: got %h, want %h", dir, obs_u, want);
        end
      end
    end
    checks++;
    if (first != ST || pops != 1) begin
      errors++;
      $display("FAIL single_latency_dir%0b: first=%0d pops=%0d, want %0d and 1", dir, first, pops, ST);
    end
  endtask

  task automatic test_streaming();
    int first, last, pops, peak;
    first = -1; last = -1; pops = 0; peak = 0;
    for (int c = 0; c < 24; c++) begin
      drive_cycle(c < 12, rand_vec(), (c % 2) == 0, 1'b1);
      if (int'(bus_u.occupancy) > peak) peak = int'(bus_u.occupancy);
      if (pu || ps) begin
        pops++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (under || pu !== ps || obs_u !== exp_u || obs_s !== exp_s) begin
          errors++;
          $display("FAIL stream_sb: got u=%h s=%h, want u=%h s=%h", obs_u, obs_s, exp_u, exp_s);
        end
      end
    end
    checks++;
    if (pops != 12 || first != ST || last != ST + 11 || peak != ST || qu.size() != 0) begin
      errors++;
      $display("FAIL stream_timing: pops=%0d first=%0d last=%0d peak=%0d left=%0d, want 12 %0d %0d %0d 0",
               pops, first, last, peak, qu.size(), ST, ST + 11, ST);
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] frozen;
    int pops;
    pops = 0;
    for (int c = 0; c < ST; c++) drive_cycle(1'b1, rand_vec(), c[0], 1'b1);
    frozen = qu[0];
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, rand_vec(), 1'b1, 1'b0);
      checks++;
      if (bus_u.in_ready !== 1'b0 || bus_u.out_valid !== 1'b1 || bus_u.occupancy !== 3'd6 ||
          obs_u !== frozen) begin
        errors++;
        $display("FAIL stall: in_ready=%b out_valid=%b occ=%0d data=%h, want 0,1,6,%h",
                 bus_u.in_ready, bus_u.out_valid, bus_u.occupancy, obs_u, frozen);
      end
    end
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      if (pu || ps) begin
        pops++;
        checks++;
        if (under || pu !== ps || obs_u !== exp_u || obs_s !== exp_s) begin
          errors++;
          $display("FAIL release_sb: got %h, want %h", obs_u, exp_u);
        end
      end
    end
    checks++;
    if (pops != ST || qu.size() != 0) begin
      errors++;
      $display("FAIL release_count: pops=%0d left=%0d, want %0d and 0", pops, qu.size(), ST);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [W-1:0] s_lo [2];
    int pops;
    a = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0};
    b = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1,
          32'hFFFF_FFFE, 32'h7FFF_FFFF};
    s_lo = '{32'hFFFF_FFFF, 32'h8000_0000};
    pops = 0;
    drive_cycle(1'b1, pack(a), 1'b1, 1'b1);
    drive_cycle(1'b1, pack(b), 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      if (pu || ps) begin
        checks++;
        if (under || pu !== ps || obs_u !== exp_u || obs_s !== exp_s ||
            obs_u[0 +: W] !== 32'h0 || obs_u[7*W +: W] !== 32'hFFFF_FFFF ||
            obs_s[0 +: W] !== s_lo[pops % 2] || obs_s[7*W +: W] !== 32'h7FFF_FFFF) begin
          errors++;
          $display("FAIL extremes%0d: u=%h s=%h, want u=%h s=%h", pops, obs_u, obs_s, exp_u, exp_s);
        end
        pops++;
      end
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL extremes_count: pops=%0d, want 2", pops);
    end
  endtask

  task automatic test_reset_midstream();
    int first, pops;
    first = -1; pops = 0;
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, rand_vec(), 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_u.out_valid !== 1'b1 || bus_u.occupancy !== 3'd3) begin
      errors++;
      $display("FAIL midstream_pre: out_valid=%b occ=%0d, want 1 and 3", bus_u.out_valid, bus_u.occupancy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_u.out_valid !== 1'b0 || bus_s.out_valid !== 1'b0 || bus_u.occupancy !== 3'd0 ||
        bus_u.out_data !== '0 || bus_u.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midstream_rst: out_valid=%b occ=%0d in_ready=%b, want 0,0,0",
               bus_u.out_valid, bus_u.occupancy, bus_u.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    qu.delete();
    qs.delete();
    drive_cycle(1'b1, rand_vec(), 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      if (pu || ps) begin
        pops++;
        if (first < 0) first = c;
        checks++;
        if (under || pu !== ps || obs_u !== exp_u || obs_s !== exp_s) begin
          errors++;
          $display("FAIL midstream_sb: got %h, want %h", obs_u, exp_u);
        end
      end
    end
    checks++;
    if (pops != 1 || first != ST) begin
      errors++;
      $display("FAIL midstream_count: pops=%0d first=%0d, want 1 and %0d", pops, first, ST);
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_streaming();
    test_backpressure();
    test_extremes();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
